// File: rtl/parity_pkg.sv
// Shared types and elaboration-time helpers for the pipelined parity tree.
package parity_pkg;

  typedef struct packed {
    logic odd;
    logic check;
    logic parity;
  } parity_side_t;

  // Partial results remaining after stage s; s = -1 gives the raw word width.
  function automatic int stage_width(int data_w, int fanin, int s);
    int w;
    w = data_w;
    for (int i = 0; i <= s; i++) w = (w + fanin - 1) / fanin;
    return w;
  endfunction

  function automatic int num_stages(int data_w, int fanin);
    int w;
    int n;
    w = data_w;
    n = 0;
    for (int i = 0; i < 64; i++) begin
      if (w > 1) begin
        w = (w + fanin - 1) / fanin;
        n++;
      end
    end
    return (n < 1) ? 1 : n;
  endfunction

  // Bit offset of tree level lvl inside the flat inter-stage bus.
  function automatic int level_offset(int data_w, int fanin, int lvl);
    int off;
    off = 0;
    for (int j = 0; j < lvl; j++) off += stage_width(data_w, fanin, j - 1);
    return off;
  endfunction

endpackage

// File: rtl/parity_stage.sv
// One registered XOR-reduction rank: groups of FANIN bits, LSB-first, short group zero-padded.
module parity_stage
  import parity_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int FANIN = 4
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              enable,
  input  logic                              in_valid,
  input  logic [IN_W-1:0]                   in_data,
  input  parity_side_t                      in_side,
  output logic                              out_valid,
  output logic [(IN_W+FANIN-1)/FANIN-1:0]   out_data,
  output parity_side_t                      out_side
);

  localparam int OUT_W = (IN_W + FANIN - 1) / FANIN;

  logic [OUT_W*FANIN-1:0] padded;
  logic [OUT_W-1:0]       reduced;

  assign padded = (OUT_W*FANIN)'(in_data);

  always_comb begin
    reduced = '0;
    for (int g = 0; g < OUT_W; g++) begin
      for (int k = 0; k < FANIN; k++) begin
        reduced[g] = reduced[g] ^ padded[g*FANIN + k];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_side  <= '0;
    end else if (enable) begin
      out_valid <= in_valid;
      out_data  <= reduced;
      out_side  <= in_side;
    end
  end

endmodule

// File: rtl/parity_pipe.sv
// Pipelined parity generator/checker: L XOR-tree ranks under one global stall,
// plus output compare and a saturating error counter.
module parity_pipe
  import parity_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int FANIN  = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_odd,
  input  logic              in_check,
  input  logic              in_parity,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_parity,
  output logic              out_error,
  output logic [CNT_W-1:0]  err_count,
  input  logic              clear_count
);

  localparam int L   = num_stages(DATA_W, FANIN);
  localparam int TOT = level_offset(DATA_W, FANIN, L + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // All tree levels packed back to back; level 0 is the raw input word.
  logic [TOT-1:0] chain;
  logic [L:0]     vld;
  parity_side_t   side [L+1];
  logic           advance;

  assign advance           = !out_valid || out_ready;
  assign in_ready          = advance;
  assign chain[DATA_W-1:0] = in_data;
  assign vld[0]            = in_valid;
  assign side[0]           = {in_odd, in_check, in_parity};

  for (genvar s = 0; s < L; s++) begin : g_stage
    localparam int IW = stage_width(DATA_W, FANIN, s - 1);
    localparam int OW = stage_width(DATA_W, FANIN, s);
    localparam int IO = level_offset(DATA_W, FANIN, s);
    localparam int OO = level_offset(DATA_W, FANIN, s + 1);

    parity_stage #(
      .IN_W  (IW),
      .FANIN (FANIN)
    ) u_stage (
      .clock     (clock),
      .reset     (reset),
      .enable    (advance),
      .in_valid  (vld[s]),
      .in_data   (chain[IO +: IW]),
      .in_side   (side[s]),
      .out_valid (vld[s+1]),
      .out_data  (chain[OO +: OW]),
      .out_side  (side[s+1])
    );
  end

  assign out_valid  = vld[L];
  assign out_parity = chain[TOT-1] ^ side[L].odd;
  assign out_error  = side[L].check & (out_parity ^ side[L].parity);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err_count <= '0;
    end else if (clear_count) begin
      err_count <= '0;
    end else if (out_valid && out_ready && out_error && (err_count != CNT_MAX)) begin
      err_count <= err_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_parity_pipe.sv
// Directed bench: default-parameter DUT (a) and DATA_W=13/FANIN=2/CNT_W=4 DUT (b).
module tb_parity_pipe;

  logic clk;
  logic rst;

  logic        a_in_valid, a_in_ready, a_in_odd, a_in_check, a_in_parity;
  logic [15:0] a_in_data;
  logic        a_out_valid, a_out_ready, a_out_parity, a_out_error, a_clear_count;
  logic [15:0] a_err_count;

  logic        b_in_valid, b_in_ready, b_in_odd, b_in_check, b_in_parity;
  logic [12:0] b_in_data;
  logic        b_out_valid, b_out_ready, b_out_parity, b_out_error, b_clear_count;
  logic [3:0]  b_err_count;

  int checks = 0;
  int errors = 0;

  parity_pipe u_a (
    .clock       (clk),
    .reset       (rst),
    .in_valid    (a_in_valid),
    .in_ready    (a_in_ready),
    .in_data     (a_in_data),
    .in_odd      (a_in_odd),
    .in_check    (a_in_check),
    .in_parity   (a_in_parity),
    .out_valid   (a_out_valid),
    .out_ready   (a_out_ready),
    .out_parity  (a_out_parity),
    .out_error   (a_out_error),
    .err_count   (a_err_count),
    .clear_count (a_clear_count)
  );

  parity_pipe #(.DATA_W(13), .FANIN(2), .CNT_W(4)) u_b (
    .clock       (clk),
    .reset       (rst),
    .in_valid    (b_in_valid),
    .in_ready    (b_in_ready),
    .in_data     (b_in_data),
    .in_odd      (b_in_odd),
    .in_check    (b_in_check),
    .in_parity   (b_in_parity),
    .out_valid   (b_out_valid),
    .out_ready   (b_out_ready),
    .out_parity  (b_out_parity),
    .out_error   (b_out_error),
    .err_count   (b_err_count),
    .clear_count (b_clear_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_a(input logic [15:0] d, input logic odd, input logic c, input logic p);
    a_in_valid  = 1'b1;
    a_in_data   = d;
    a_in_odd    = odd;
    a_in_check  = c;
    a_in_parity = p;
    tick();
    a_in_valid  = 1'b0;
  endtask

  task automatic send_b(input logic [12:0] d, input logic odd, input logic c, input logic p);
    b_in_valid  = 1'b1;
    b_in_data   = d;
    b_in_odd    = odd;
    b_in_check  = c;
    b_in_parity = p;
    tick();
    b_in_valid  = 1'b0;
  endtask

  logic [15:0] bp_d   [5] = '{16'h0001, 16'h0003, 16'h0007, 16'h000F, 16'h001F};
  logic        bp_exp [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    int  sent, got, hold, lat;
    bit  held_done;
    logic held_par;

    a_in_valid = 0; a_in_data = '0; a_in_odd = 0; a_in_check = 0; a_in_parity = 0;
    a_out_ready = 1; a_clear_count = 0;
    b_in_valid = 0; b_in_data = '0; b_in_odd = 0; b_in_check = 0; b_in_parity = 0;
    b_out_ready = 1; b_clear_count = 0;

    // Reset state
    rst = 1'b0;
    #1 rst = 1'b1;
    #2;
    chk("rst_valid", a_out_valid, 0);
    chk("rst_parity", a_out_parity, 0);
    chk("rst_error", a_out_error, 0);
    chk("rst_count", a_err_count, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    a_out_ready = 1'b0;
    #1;
    chk("rst_in_ready", a_in_ready, 1);
    chk("b_in_ready", b_in_ready, 1);
    a_out_ready = 1'b1;
    tick();

    // Even parity stream, latency L-1 = 1 edge after acceptance
    send_a(16'h0001, 0, 0, 0);
    chk("even_lat_early", a_out_valid, 0);
    send_a(16'hFFFF, 0, 0, 0);
    chk("even_v0", a_out_valid, 1);
    chk("even_p0001", a_out_parity, 1);
    send_a(16'h8421, 0, 0, 0);
    chk("even_pFFFF", a_out_parity, 0);
    tick();
    chk("even_p8421", a_out_parity, 0);
    chk("even_v2", a_out_valid, 1);
    tick();
    chk("even_drain", a_out_valid, 0);

    // Odd parity
    send_a(16'hFFFF, 1, 0, 0);
    send_a(16'h0000, 1, 0, 0);
    chk("odd_pFFFF", a_out_parity, 1);
    tick();
    chk("odd_p0000", a_out_parity, 1);
    tick();

    // Check mode
    send_a(16'h0003, 0, 1, 1);
    tick();
    chk("chk_err", a_out_error, 1);
    chk("chk_par", a_out_parity, 0);
    tick();
    chk("chk_cnt1", a_err_count, 1);
    send_a(16'h0003, 0, 0, 1);
    tick();
    chk("nochk_err", a_out_error, 0);
    chk("nochk_valid", a_out_valid, 1);
    tick();
    chk("nochk_cnt", a_err_count, 1);
    send_a(16'h0007, 0, 1, 1);
    tick();
    chk("match_err", a_out_error, 0);
    send_a(16'h0007, 1, 1, 1);
    tick();
    chk("oddchk_err", a_out_error, 1);
    tick();
    chk("oddchk_cnt", a_err_count, 2);

    // Back-pressure: hold out_ready low for 3 cycles once the first result shows
    sent = 0; got = 0; hold = 0; held_done = 0; held_par = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (a_out_valid && !held_done && hold == 0) begin
        hold = 3;
        held_par = a_out_parity;
      end
      a_out_ready = (hold == 0);
      if (sent < 5) begin
        a_in_valid = 1'b1;
        a_in_data  = bp_d[sent];
        a_in_odd   = 0; a_in_check = 0; a_in_parity = 0;
      end else begin
        a_in_valid = 1'b0;
      end
      #1;
      if (hold > 0) begin
        chk("bp_in_ready", a_in_ready, 0);
        chk("bp_stable", a_out_parity, held_par);
        hold--;
        if (hold == 0) held_done = 1;
      end
      if (a_out_valid && a_out_ready) begin
        if (got < 5) chk("bp_order", a_out_parity, bp_exp[got]);
        got++;
      end
      if (a_in_valid && a_in_ready) sent++;
      tick();
    end
    a_in_valid  = 1'b0;
    a_out_ready = 1'b1;
    chk("bp_count", got, 5);

    // Reset with beats in flight
    send_a(16'h0001, 0, 0, 0);
    send_a(16'h0003, 0, 0, 0);
    rst = 1'b1;
    #1;
    chk("midrst_valid", a_out_valid, 0);
    chk("midrst_count", a_err_count, 0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("midrst_stale", a_out_valid, 0);
    end
    send_a(16'h8000, 0, 0, 0);
    chk("postrst_early", a_out_valid, 0);
    tick();
    chk("postrst_valid", a_out_valid, 1);
    chk("postrst_par", a_out_parity, 1);
    tick();

    // DATA_W=13, FANIN=2: four ranks
    send_b(13'h1FFF, 0, 0, 0);
    lat = 0;
    while (!b_out_valid && lat < 10) begin
      tick();
      lat++;
    end
    chk("b_latency", lat, 3);
    chk("b_p1FFF", b_out_parity, 1);
    tick();
    send_b(13'h1554, 1, 0, 0);
    tick(); tick(); tick();
    chk("b_p1554_odd", b_out_parity, 1);
    tick();

    // CNT_W=4 saturation
    for (int i = 0; i < 17; i++) send_b(13'h0000, 0, 1, 1);
    for (int i = 0; i < 5; i++) tick();
    chk("b_saturate", b_err_count, 15);

    b_clear_count = 1'b1;
    tick();
    b_clear_count = 1'b0;
    chk("b_clear", b_err_count, 0);

    // Clear coincident with an errored transfer
    send_b(13'h0000, 0, 1, 1);
    lat = 0;
    while (!b_out_valid && lat < 10) begin
      tick();
      lat++;
    end
    chk("b_clr_err_vis", b_out_error, 1);
    b_clear_count = 1'b1;
    tick();
    b_clear_count = 1'b0;
    chk("b_clear_wins", b_err_count, 0);

    send_b(13'h0000, 0, 1, 1);
    lat = 0;
    while (!b_out_valid && lat < 10) begin
      tick();
      lat++;
    end
    tick();
    chk("b_inc_after_clr", b_err_count, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
